// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output stage: counter widths, the full-duty code
// and the per-pin output selection rule.
package pwm_pkg;

  localparam int PWM_BITS = 8;
  localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;
  localparam logic [PWM_BITS-1:0] CNT_LAST = 8'hFF;
  localparam int NUM_OUT = 16;

  typedef enum logic [1:0] {
    PIN_OFF  = 2'd0,
    PIN_HIGH = 2'd1,
    PIN_PWM  = 2'd2
  } pin_mode_e;

  // The enable bit gates everything; the PWM bit picks between static high and the shared waveform.
  function automatic logic pin_next(input logic en_out, input logic en_pwm, input logic level);
    pin_mode_e mode;
    logic      value;
    value = 1'b0;
    if (!en_out) begin
      mode = PIN_OFF;
    end else if (en_pwm) begin
      mode = PIN_PWM;
    end else begin
      mode = PIN_HIGH;
    end
    case (mode)
      PIN_OFF:  value = 1'b0;
      PIN_HIGH: value = 1'b1;
      PIN_PWM:  value = level;
      default:  value = 1'b0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/pwm_output_stage_if.sv
// Control register bundle from the SPI register file into the PWM output stage.
interface pwm_output_stage_if;

  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  // The register file owns these values; the output stage only reads them.
  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle
  );

  modport slave (
    input en_reg_out_7_0,
    input en_reg_out_15_8,
    input en_reg_pwm_7_0,
    input en_reg_pwm_15_8,
    input pwm_duty_cycle
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Free-running divider: emits a one-clk tick every PRESCALE clocks to step the PWM counter.
module pwm_prescaler #(
  parameter int PRESCALE = 13
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  // A 1-bit counter is kept even for PRESCALE=1 so the logic stays uniform; it then never leaves 0.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_output_stage.sv
// Drives the 16 user pins from the SPI control registers: off, static high, or PWM
// at a shared, period-boundary double-buffered duty cycle.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_output_stage_if.slave   regs,
  output logic [NUM_OUT-1:0]  out,
  output logic                period_start
);

  logic                tick;
  logic                boundary;
  logic                pwm_level;
  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty_shadow;
  logic [NUM_OUT-1:0]  en_out;
  logic [NUM_OUT-1:0]  en_pwm;
  logic [NUM_OUT-1:0]  out_next;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign en_out   = {regs.en_reg_out_15_8, regs.en_reg_out_7_0};
  assign en_pwm   = {regs.en_reg_pwm_15_8, regs.en_reg_pwm_7_0};
  assign boundary = tick && (cnt == CNT_LAST);

  // Full-scale duty is special-cased so 0xFF gives a solid high with no one-step gap at the wrap.
  always_comb begin
    pwm_level = 1'b0;
    out_next  = '0;
    pwm_level = (duty_shadow == DUTY_FULL) || (cnt < duty_shadow);
    for (int i = 0; i < NUM_OUT; i++) begin
      out_next[i] = pin_next(en_out[i], en_pwm[i], pwm_level);
    end
  end

  // Duty is captured only on the wrap edge, so a period always runs with a single compare value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      duty_shadow  <= '0;
      period_start <= 1'b0;
      out          <= '0;
    end else begin
      if (tick) begin
        cnt <= cnt + PWM_BITS'(1);
      end
      if (boundary) begin
        duty_shadow <= regs.pwm_duty_cycle;
      end
      period_start <= boundary;
      out          <= out_next;
    end
  end

endmodule

// File: tb/tb_pwm_output_stage.sv
// Scoreboard bench for pwm_output_stage at PRESCALE=2 (512-clk period).
module tb_pwm_output_stage;

  localparam int PRESCALE = 2;
  localparam int PERIOD   = PRESCALE * 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] out;
  logic        period_start;

  pwm_output_stage_if regs_if ();

  pwm_output_stage #(
    .PRESCALE (PRESCALE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .regs         (regs_if),
    .out          (out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    pin;
    int    exp_high;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   hi_cnt[16];
  int   last_high[16];
  int   ps_count;
  bit   ps_at_end;

  task automatic set_regs(input logic [15:0] en_o, input logic [15:0] en_p, input logic [7:0] duty);
    regs_if.en_reg_out_7_0  = en_o[7:0];
    regs_if.en_reg_out_15_8 = en_o[15:8];
    regs_if.en_reg_pwm_7_0  = en_p[7:0];
    regs_if.en_reg_pwm_15_8 = en_p[15:8];
    regs_if.pwm_duty_cycle  = duty;
  endtask

  task automatic push_exp(input string name, input int pin, input int exp_high);
    exp_t e;
    e.name = name;
    e.pin = pin;
    e.exp_high = exp_high;
    sb.push_back(e);
  endtask

  // Always advances at least one clk so a caller sitting on a strobe reaches the next one.
  task automatic wait_period_start(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 2 * PERIOD + 8);
    if (period_start !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: period_start timeout after %0d clk, required a strobe", name, n);
    end
  endtask

  // Samples one full period; sample k reflects the k-th count step after the strobe.
  task automatic measure_period(input int change_k, input logic [7:0] new_duty);
    for (int p = 0; p < 16; p++) begin
      hi_cnt[p] = 0;
      last_high[p] = 0;
    end
    ps_count = 0;
    ps_at_end = 1'b0;
    for (int k = 1; k <= PERIOD; k++) begin
      @(negedge clk);
      for (int p = 0; p < 16; p++) begin
        if (out[p] === 1'b1) begin
          hi_cnt[p]++;
          last_high[p] = k;
        end
      end
      if (period_start === 1'b1) begin
        if (k == PERIOD) ps_at_end = 1'b1;
        else ps_count++;
      end
      if (k == change_k) regs_if.pwm_duty_cycle = new_duty;
    end
  endtask

  task automatic test_reset();
    int n;
    bit seen;
    set_regs(16'hFFFF, 16'h0000, 8'h80);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (out !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_out: got %h, required 0000", out);
    end
    tests_run++;
    if (period_start !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_period_start: got %b, required 0", period_start);
    end
    rst_n = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        tests_run++;
        if (out !== 16'hFFFF) begin
          tests_failed++;
          $display("[TB] FAIL static_on_after_release: got %h, required ffff", out);
        end
      end
      if (period_start === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen || n != PERIOD) begin
      tests_failed++;
      $display("[TB] FAIL first_period_start: strobe at clk %0d (seen=%0d), required %0d", n, seen, PERIOD);
    end
    push_exp("static_on_pin0", 0, PERIOD);
    push_exp("static_on_pin15", 15, PERIOD);
    measure_period(-1, 8'h00);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      tests_run++;
      if (hi_cnt[e.pin] !== e.exp_high || last_high[e.pin] !== e.exp_high) begin
        tests_failed++;
        $display("[TB] FAIL %s: high=%0d last_high=%0d, required %0d", e.name, hi_cnt[e.pin], last_high[e.pin], e.exp_high);
      end
    end
    tests_run++;
    if (!ps_at_end || ps_count != 0) begin
      tests_failed++;
      $display("[TB] FAIL period_spacing: end_strobe=%0d extra=%0d, required 1 and 0", ps_at_end, ps_count);
    end
  endtask

  task automatic test_first_period();
    set_regs(16'hFFFF, 16'hFFFF, 8'h80);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_exp("first_period_pin0", 0, 0);
    push_exp("first_period_pin15", 15, 0);
    measure_period(-1, 8'h00);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      tests_run++;
      if (hi_cnt[e.pin] !== e.exp_high || last_high[e.pin] !== e.exp_high) begin
        tests_failed++;
        $display("[TB] FAIL %s: high=%0d last_high=%0d, required %0d", e.name, hi_cnt[e.pin], last_high[e.pin], e.exp_high);
      end
    end
    tests_run++;
    if (!ps_at_end || ps_count != 0) begin
      tests_failed++;
      $display("[TB] FAIL first_period_strobe: end_strobe=%0d extra=%0d, required 1 and 0", ps_at_end, ps_count);
    end
    push_exp("second_period_pin0", 0, 256);
    push_exp("second_period_pin8", 8, 256);
    push_exp("second_period_pin15", 15, 256);
    measure_period(-1, 8'h00);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      tests_run++;
      if (hi_cnt[e.pin] !== e.exp_high || last_high[e.pin] !== e.exp_high) begin
        tests_failed++;
        $display("[TB] FAIL %s: high=%0d last_high=%0d, required %0d", e.name, hi_cnt[e.pin], last_high[e.pin], e.exp_high);
      end
    end
  endtask

  task automatic test_duty_sweep();
    logic [7:0] duties[4];
    int         exps[4];
    duties[0] = 8'h00; exps[0] = 0;
    duties[1] = 8'h01; exps[1] = 2;
    duties[2] = 8'hFE; exps[2] = 508;
    duties[3] = 8'hFF; exps[3] = 512;
    set_regs(16'h0001, 16'h0001, 8'h00);
    for (int d = 0; d < 4; d++) begin
      regs_if.pwm_duty_cycle = duties[d];
      wait_period_start("duty_sweep");
      push_exp($sformatf("duty_%02h_pin0", duties[d]), 0, exps[d]);
      push_exp($sformatf("duty_%02h_pin1_off", duties[d]), 1, 0);
      measure_period(-1, 8'h00);
      while (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        tests_run++;
        if (hi_cnt[e.pin] !== e.exp_high || last_high[e.pin] !== e.exp_high) begin
          tests_failed++;
          $display("[TB] FAIL %s: high=%0d last_high=%0d, required %0d", e.name, hi_cnt[e.pin], last_high[e.pin], e.exp_high);
        end
      end
    end
    push_exp("duty_ff_back_to_back", 0, PERIOD);
    measure_period(-1, 8'h00);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      tests_run++;
      if (hi_cnt[e.pin] !== e.exp_high || last_high[e.pin] !== e.exp_high) begin
        tests_failed++;
        $display("[TB] FAIL %s: high=%0d last_high=%0d, required %0d", e.name, hi_cnt[e.pin], last_high[e.pin], e.exp_high);
      end
    end
  endtask

  task automatic test_mid_period_change();
    set_regs(16'h0001, 16'h0001, 8'h40);
    wait_period_start("mid_change");
    push_exp("mid_change_current", 0, 128);
    measure_period(32, 8'hC0);
    push_exp("mid_change_next", 0, 384);
    while (sb.size() > 1) begin
      exp_t e;
      e = sb.pop_front();
      tests_run++;
      if (hi_cnt[e.pin] !== e.exp_high || last_high[e.pin] !== e.exp_high) begin
        tests_failed++;
        $display("[TB] FAIL %s: high=%0d last_high=%0d, required %0d", e.name, hi_cnt[e.pin], last_high[e.pin], e.exp_high);
      end
    end
    measure_period(-1, 8'h00);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      tests_run++;
      if (hi_cnt[e.pin] !== e.exp_high || last_high[e.pin] !== e.exp_high) begin
        tests_failed++;
        $display("[TB] FAIL %s: high=%0d last_high=%0d, required %0d", e.name, hi_cnt[e.pin], last_high[e.pin], e.exp_high);
      end
    end
  endtask

  task automatic test_mixed_enables();
    set_regs(16'h00FF, 16'h0F0F, 8'h80);
    wait_period_start("mixed");
    for (int p = 0; p < 16; p++) begin
      push_exp($sformatf("mixed_pin%0d", p), p, (p < 4) ? 256 : ((p < 8) ? PERIOD : 0));
    end
    measure_period(-1, 8'h00);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      tests_run++;
      if (hi_cnt[e.pin] !== e.exp_high || last_high[e.pin] !== e.exp_high) begin
        tests_failed++;
        $display("[TB] FAIL %s: high=%0d last_high=%0d, required %0d", e.name, hi_cnt[e.pin], last_high[e.pin], e.exp_high);
      end
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (out[0] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pin0_high_before_disable: got %b, required 1", out[0]);
    end
    regs_if.en_reg_out_7_0 = 8'hFE;
    @(negedge clk);
    tests_run++;
    if (out[0] !== 1'b0 || out[1] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pin0_disable_latency: got pin0=%b pin1=%b, required 0 and 1", out[0], out[1]);
    end
  endtask

  task automatic test_reset_mid_period();
    set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
    wait_period_start("reset_mid_sync");
    wait_period_start("reset_mid_sync2");
    repeat (288) @(negedge clk);
    tests_run++;
    if (out !== 16'hFFFF) begin
      tests_failed++;
      $display("[TB] FAIL before_mid_reset: got %h, required ffff", out);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_clear: out=%h period_start=%b, required 0000 and 0", out, period_start);
    end
    rst_n = 1'b1;
    push_exp("after_mid_reset_pin0", 0, 0);
    push_exp("after_mid_reset_pin15", 15, 0);
    measure_period(-1, 8'h00);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      tests_run++;
      if (hi_cnt[e.pin] !== e.exp_high || last_high[e.pin] !== e.exp_high) begin
        tests_failed++;
        $display("[TB] FAIL %s: high=%0d last_high=%0d, required %0d", e.name, hi_cnt[e.pin], last_high[e.pin], e.exp_high);
      end
    end
    tests_run++;
    if (!ps_at_end || ps_count != 0) begin
      tests_failed++;
      $display("[TB] FAIL cnt_restart: end_strobe=%0d extra=%0d, required 1 and 0", ps_at_end, ps_count);
    end
    push_exp("after_mid_reset_next", 0, PERIOD);
    measure_period(-1, 8'h00);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      tests_run++;
      if (hi_cnt[e.pin] !== e.exp_high || last_high[e.pin] !== e.exp_high) begin
        tests_failed++;
        $display("[TB] FAIL %s: high=%0d last_high=%0d, required %0d", e.name, hi_cnt[e.pin], last_high[e.pin], e.exp_high);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    set_regs(16'h0000, 16'h0000, 8'h00);
    test_reset();
    test_first_period();
    test_duty_sweep();
    test_mid_period_change();
    test_mixed_enables();
    test_reset_mid_period();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
